// File: rtl/comb_engine.sv
// comb_engine: binomial-coefficient engine.
// Computes C(n,k) by walking the Pascal recursion depth-first on an internal
// LIFO of {n,k} pairs and counting the leaves (k==0 or k==n) that it reaches.
// Handshake: start (sampled in IDLE) / busy / one-cycle done pulse.
// Stack overflow aborts the run with a sticky error flag; the counter
// saturates at all-ones with a sticky sat flag and the run carries on.

module comb_engine #(
   parameter int N_WIDTH      = 4,
   parameter int STACK_DEPTH  = 16,
   parameter int RESULT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [N_WIDTH-1:0]      n_in,
   input  logic [N_WIDTH-1:0]      k_in,
   output logic                    busy,
   output logic                    done,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    error,
   output logic                    sat
);

   // sp counts 0..STACK_DEPTH inclusive, so it needs one more code than the
   // memory address does.
   localparam int SP_WIDTH   = $clog2(STACK_DEPTH + 1);
   localparam int ADDR_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int ENTRY_W    = 2 * N_WIDTH;

   localparam logic [SP_WIDTH-1:0] SP_FULL = SP_WIDTH'(STACK_DEPTH);
   localparam logic [SP_WIDTH-1:0] SP_ONE  = SP_WIDTH'(1);
   localparam logic [N_WIDTH-1:0]  N_ONE   = N_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_POP    = 3'd2,
      S_EVAL   = 3'd3,
      S_PUSH_A = 3'd4,
      S_PUSH_B = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   state_t                  r_state;
   logic [SP_WIDTH-1:0]     r_sp;
   logic [N_WIDTH-1:0]      r_n_lat;
   logic [N_WIDTH-1:0]      r_k_lat;
   logic [N_WIDTH-1:0]      r_cur_n;
   logic [N_WIDTH-1:0]      r_cur_k;
   logic [RESULT_WIDTH-1:0] r_result;
   logic                    r_error;
   logic                    r_sat;

   // Stack storage: plain array, written on push, read registered on pop.
   logic [ENTRY_W-1:0]      r_stack_mem [STACK_DEPTH];

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   state_t                  w_state_next;
   logic                    w_accept;     // start taken in IDLE
   logic                    w_load;       // root push, restarts the stack
   logic                    w_push_req;   // child push from PUSH_A/PUSH_B
   logic [ENTRY_W-1:0]      w_push_data;
   logic                    w_pop;        // latch top entry, sp--
   logic                    w_leaf;       // count one leaf
   logic                    w_full;
   logic                    w_overflow;
   logic                    w_mem_we;
   logic [ADDR_WIDTH-1:0]   w_mem_addr;
   logic [ENTRY_W-1:0]      w_mem_wdata;
   logic [SP_WIDTH-1:0]     w_sp_minus1;
   logic [ADDR_WIDTH-1:0]   w_top_addr;
   logic [N_WIDTH-1:0]      w_n_minus1;
   logic [N_WIDTH-1:0]      w_k_minus1;
   logic                    w_result_max;

   assign w_full       = (r_sp == SP_FULL);
   assign w_overflow   = w_push_req & w_full;
   assign w_sp_minus1  = r_sp - SP_ONE;
   assign w_top_addr   = w_sp_minus1[ADDR_WIDTH-1:0];
   assign w_n_minus1   = r_cur_n - N_ONE;
   assign w_k_minus1   = r_cur_k - N_ONE;
   assign w_result_max = &r_result;

   // The root always lands in slot 0 regardless of where a previous
   // (possibly aborted) run left sp; children go to mem[sp].
   assign w_mem_we    = w_load | (w_push_req & ~w_full);
   assign w_mem_addr  = w_load ? '0 : r_sp[ADDR_WIDTH-1:0];
   assign w_mem_wdata = w_load ? {r_n_lat, r_k_lat} : w_push_data;

   // Next-state and datapath strobes for the traversal FSM.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_load       = 1'b0;
      w_push_req   = 1'b0;
      w_push_data  = '0;
      w_pop        = 1'b0;
      w_leaf       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_LOAD;
            end
         end

         S_LOAD: begin
            w_load       = 1'b1;
            w_state_next = S_POP;
         end

         S_POP: begin
            if (r_sp == '0) begin
               w_state_next = S_DONE;
            end else begin
               w_pop        = 1'b1;
               w_state_next = S_EVAL;
            end
         end

         S_EVAL: begin
            if (r_cur_k > r_cur_n) begin
               // Only the root can be out of range; it contributes nothing.
               w_state_next = S_POP;
            end else if ((r_cur_k == '0) || (r_cur_k == r_cur_n)) begin
               w_leaf       = 1'b1;
               w_state_next = S_POP;
            end else begin
               w_state_next = S_PUSH_A;
            end
         end

         S_PUSH_A: begin
            w_push_req  = 1'b1;
            w_push_data = {w_n_minus1, w_k_minus1};
            w_state_next = w_full ? S_DONE : S_PUSH_B;
         end

         S_PUSH_B: begin
            w_push_req  = 1'b1;
            w_push_data = {w_n_minus1, r_cur_k};
            w_state_next = w_full ? S_DONE : S_POP;
         end

         S_DONE: begin
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Stack write port; contents need no reset because sp gates every read.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_stack_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   // Stack pointer and operand registers (latched inputs, popped node).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sp    <= '0;
         r_n_lat <= '0;
         r_k_lat <= '0;
         r_cur_n <= '0;
         r_cur_k <= '0;
      end else begin
         if (w_accept) begin
            r_n_lat <= n_in;
            r_k_lat <= k_in;
         end

         if (w_load) begin
            r_sp <= SP_ONE;
         end else if (w_pop) begin
            r_sp <= w_sp_minus1;
         end else if (w_push_req && !w_full) begin
            r_sp <= r_sp + SP_ONE;
         end

         if (w_pop) begin
            {r_cur_n, r_cur_k} <= r_stack_mem[w_top_addr];
         end
      end
   end

   // Leaf counter with saturation, plus the sticky error and sat flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_result <= '0;
         r_error  <= 1'b0;
         r_sat    <= 1'b0;
      end else begin
         if (w_load) begin
            r_result <= '0;
            r_error  <= 1'b0;
            r_sat    <= 1'b0;
         end else begin
            if (w_leaf) begin
               if (w_result_max) begin
                  r_sat <= 1'b1;
               end else begin
                  r_result <= r_result + RESULT_WIDTH'(1);
               end
            end
            if (w_overflow) begin
               r_error <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign error  = r_error;
   assign sat    = r_sat;

endmodule

// File: tb/tb_comb_engine.sv
// tb_comb_engine: self-checking bench for comb_engine.
// Three instances share the inputs: default parameters, a 2-entry stack
// (overflow behaviour) and a 2-bit result (saturation behaviour).
// Expected values come from closed-form binomials and a latency formula.

module tb_comb_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  n_in = '0;
   logic [3:0]  k_in = '0;

   logic        busy0, done0, error0, sat0;
   logic [15:0] result0;
   logic        busy_sd, done_sd, error_sd, sat_sd;
   logic [15:0] result_sd;
   logic        busy_rw, done_rw, error_rw, sat_rw;
   logic [1:0]  result_rw;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   comb_engine u_dut (
      .clk(clk), .rst(rst), .start(start), .n_in(n_in), .k_in(k_in),
      .busy(busy0), .done(done0), .result(result0), .error(error0), .sat(sat0)
   );

   comb_engine #(.STACK_DEPTH(2)) u_dut_sd (
      .clk(clk), .rst(rst), .start(start), .n_in(n_in), .k_in(k_in),
      .busy(busy_sd), .done(done_sd), .result(result_sd), .error(error_sd), .sat(sat_sd)
   );

   comb_engine #(.RESULT_WIDTH(2)) u_dut_rw (
      .clk(clk), .rst(rst), .start(start), .n_in(n_in), .k_in(k_in),
      .busy(busy_rw), .done(done_rw), .result(result_rw), .error(error_rw), .sat(sat_rw)
   );

   // Reference: plain binomial coefficient, 0 when k > n.
   function automatic longint binom(input int n, input int k);
      longint r;
      if (k > n) return 0;
      r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   // Reference: edges from the start-sampling edge to DONE entry.
   function automatic int model_lat(input int n, input int k);
      longint leaves;
      leaves = (k > n) ? 1 : binom(n, k);
      return int'(6 * leaves - 2);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One transaction: pulse start, then watch every instance until the
   // default instance has returned to IDLE. Optionally re-pulse start with
   // different operands while busy.
   task automatic run_op(input int n, input int k, input bit glitch,
                         output int lat0, output int lat_sd, output int lat_rw,
                         output int busy_cycles);
      int cnt;
      lat0 = -1; lat_sd = -1; lat_rw = -1;
      @(negedge clk);
      start = 1'b1; n_in = 4'(n); k_in = 4'(k);
      @(posedge clk); #1;
      start = 1'b0;
      busy_cycles = busy0 ? 1 : 0;
      cnt = 0;
      while (cnt < 3000) begin
         @(posedge clk); #1;
         cnt++;
         if (glitch && cnt == 5) begin
            start = 1'b1; n_in = 4'd7; k_in = 4'd3;
         end
         if (glitch && cnt == 6) begin
            start = 1'b0; n_in = 4'(n); k_in = 4'(k);
         end
         if (done0 && lat0 < 0) lat0 = cnt;
         if (done_sd && lat_sd < 0) lat_sd = cnt;
         if (done_rw && lat_rw < 0) lat_rw = cnt;
         if (busy0) busy_cycles++;
         if (lat0 >= 0 && cnt == lat0 + 1) break;
      end
      if (lat0 < 0) check("timeout", 0, 1);
   endtask

   typedef struct {
      int n;
      int k;
      int exp_res;
      int exp_lat;
      int exp_rw_res;
      int exp_rw_sat;
      int exp_sd_err;
      int exp_sd_res;
      int exp_sd_lat;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int l0, lsd, lrw, bc;
      longint c;

      vecs[0] = '{4, 2,  6, 34, 3, 1, 1, 0,  9};
      vecs[1] = '{5, 0,  1,  4, 1, 0, 0, 1,  4};
      vecs[2] = '{3, 5,  0,  4, 0, 0, 0, 0,  4};
      vecs[3] = '{2, 1,  2, 10, 2, 0, 0, 2, 10};
      vecs[4] = '{1, 1,  1,  4, 1, 0, 0, 1,  4};
      vecs[5] = '{5, 2, 10, 58, 3, 1, 1, 0,  9};
      vecs[6] = '{0, 0,  1,  4, 1, 0, 0, 1,  4};
      vecs[7] = '{3, 1,  3, 16, 3, 0, 1, 0,  9};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_result", result0, 0);
      check("rst_error", error0, 0);
      check("rst_sat", sat0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Table-driven directed vectors.
      foreach (vecs[i]) begin
         run_op(vecs[i].n, vecs[i].k, 1'b0, l0, lsd, lrw, bc);
         $display("vec %0d: C(%0d,%0d) result=%0d lat=%0d rw=%0d/%0d sd_err=%0d",
                  i, vecs[i].n, vecs[i].k, result0, l0, result_rw, sat_rw, error_sd);
         check("vec_result", result0, vecs[i].exp_res);
         check("vec_lat", l0, vecs[i].exp_lat);
         check("vec_busy_cycles", bc, vecs[i].exp_lat + 1);
         check("vec_done_pulse", done0, 0);
         check("vec_error", error0, 0);
         check("vec_sat", sat0, 0);
         check("vec_rw_result", result_rw, vecs[i].exp_rw_res);
         check("vec_rw_sat", sat_rw, vecs[i].exp_rw_sat);
         check("vec_rw_lat", lrw, vecs[i].exp_lat);
         check("vec_sd_error", error_sd, vecs[i].exp_sd_err);
         check("vec_sd_result", result_sd, vecs[i].exp_sd_res);
         check("vec_sd_lat", lsd, vecs[i].exp_sd_lat);
      end

      // Overflow then a clean run: error must clear on the new start.
      run_op(4, 2, 1'b0, l0, lsd, lrw, bc);
      check("ovf_error", error_sd, 1);
      run_op(1, 1, 1'b0, l0, lsd, lrw, bc);
      $display("clear: sd result=%0d error=%0d", result_sd, error_sd);
      check("clr_sd_error", error_sd, 0);
      check("clr_sd_result", result_sd, 1);
      check("clr_rw_sat", sat_rw, 0);

      // Start pulsed while busy with different operands: ignored.
      run_op(4, 2, 1'b1, l0, lsd, lrw, bc);
      $display("glitch: result=%0d lat=%0d", result0, l0);
      check("glitch_result", result0, 6);
      check("glitch_lat", l0, 34);
      check("glitch_idle", busy0, 0);

      // Mid-run reset discards the run.
      @(negedge clk);
      start = 1'b1; n_in = 4'd6; k_in = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      $display("midrst: busy=%0d done=%0d result=%0d", busy0, done0, result0);
      check("midrst_busy", busy0, 0);
      check("midrst_done", done0, 0);
      check("midrst_result", result0, 0);
      check("midrst_error", error0, 0);
      check("midrst_sat", sat0, 0);
      check("midrst_sd_error", error_sd, 0);
      check("midrst_rw_sat", sat_rw, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_still_idle", busy0, 0);
      run_op(6, 3, 1'b0, l0, lsd, lrw, bc);
      $display("restart: C(6,3) result=%0d lat=%0d", result0, l0);
      check("restart_result", result0, 20);
      check("restart_lat", l0, 118);

      // Randomized operands against the arithmetic model.
      for (int t = 0; t < 30; t++) begin
         int n, k;
         n = int'($urandom_range(8, 0));
         k = int'($urandom_range(9, 0));
         c = binom(n, k);
         run_op(n, k, 1'b0, l0, lsd, lrw, bc);
         $display("rand %0d: C(%0d,%0d) result=%0d lat=%0d rw=%0d/%0d",
                  t, n, k, result0, l0, result_rw, sat_rw);
         check("rand_result", result0, c);
         check("rand_lat", l0, model_lat(n, k));
         check("rand_busy_cycles", bc, model_lat(n, k) + 1);
         check("rand_sat", sat0, 0);
         check("rand_rw_result", result_rw, (c > 3) ? 3 : c);
         check("rand_rw_sat", sat_rw, (c > 3) ? 1 : 0);
         check("rand_rw_lat", lrw, model_lat(n, k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/comb_engine.md
# comb_engine

Parametrised binomial-coefficient engine that computes C(n,k) with the recursion C(n,k) = C(n-1,k-1) + C(n-1,k) and base case C(n,0) = C(n,n) = 1. It combines the controller FSM, an internal register-file stack and the result accumulator in one block with a start/busy/done handshake. It adds width and stack-depth parameters, stack-overflow detection, result saturation and k>n handling. It is the self-contained successor to the fixed-width controller/datapath pair in the Recursive Combination design.

## Interface
- N_WIDTH, 4: width of n, k and of each stack field.
- STACK_DEPTH, 16: number of stack entries. Each entry is {n, k}, 2*N_WIDTH bits.
- RESULT_WIDTH, 16: accumulator width.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- n_in  input  N_WIDTH  n operand, latched on an accepted start.
- k_in  input  N_WIDTH  k operand, latched on an accepted start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in state DONE.
- result  output  RESULT_WIDTH  accumulated count. Valid from the done pulse until the next accepted start.
- error  output  1  stack overflow occurred. Sticky until the next accepted start.
- sat  output  1  result saturated. Sticky until the next accepted start.

## Operation
- States: IDLE, LOAD, POP, EVAL, PUSH_A, PUSH_B, DONE.
- IDLE: if start=1, go to LOAD. Otherwise stay in IDLE. Start is ignored in all other states.
- LOAD: push {n_in,k_in} (sp becomes 1). Clear result, error and sat. Go to POP.
- POP:
  - If sp==0, go to DONE.
  - Otherwise latch the top entry into cur_n/cur_k, decrement sp, go to EVAL.
- EVAL:
  - If cur_k > cur_n: no increment, go to POP. Only the root can hit this case.
  - Else if cur_k==0 or cur_k==cur_n: result+1, go to POP.
  - Otherwise go to PUSH_A.
- PUSH_A: push {cur_n-1, cur_k-1}. Go to PUSH_B.
- PUSH_B: push {cur_n-1, cur_k}. Go to POP.
- DONE: done=1 for one cycle, then IDLE.
- Stack is LIFO, sp ranges 0..STACK_DEPTH. Push writes mem[sp] and then increments sp. Pop reads mem[sp-1].
- Overflow: a push attempted with sp==STACK_DEPTH does not write. Set error=1 and go directly to DONE. result then holds the partial count and is invalid.
- Occupancy never exceeds n+1, so the defaults are overflow-free for all n ≤ 15.
- Saturation: an increment with result == all-ones leaves result unchanged and sets sat=1. The run continues.
- Arithmetic is unsigned. cur_n-1 and cur_k-1 are only formed in non-leaf EVAL paths, so no underflow is possible.

## Timing
- Reset values (rst=0 at a clock edge): state=IDLE, sp=0, busy=0, done=0, result=0, error=0, sat=0.
- Reset has priority over all other activity, including mid-operation; the run is discarded.
- Cycle cost:
  - Leaf node (including the k>n root): 2 cycles (POP, EVAL).
  - Internal node: 4 cycles (POP, EVAL, PUSH_A, PUSH_B).
- Latency: with L = C(n,k) (L=1 for the k>n case), DONE is entered 6L-2 edges after the edge that samples start.
  - Examples: C(5,0) → 4; C(2,1) → 10; C(4,2) → 34.
- busy rises on the edge after start is sampled and falls on the edge after DONE.
- A new start can be accepted in the first IDLE cycle after DONE.
- result, error and sat hold their values through IDLE.

## Test plan
- n=4, k=2, start for one cycle → done pulse 34 edges later, result=6, error=0, sat=0; busy high for exactly 35 cycles.
- n=5, k=0 → done after 4 edges, result=1. Then n=3, k=5 → done after 4 edges, result=0.
- STACK_DEPTH=2, n=4, k=2 → error=1 with done pulse at the first overflowing push; second start with n=1, k=1 clears error, result=1.
- RESULT_WIDTH=2, n=4, k=2 → result=3, sat=1, done at 34 edges (saturation does not shorten the run).
- Start with n=6, k=3; pulse rst=0 for one cycle 10 edges in → all outputs 0 and state IDLE next cycle. Restart → result=20.
- Start with n=4, k=2, then change n_in/k_in and pulse start while busy → ignored; result=6 at 34 edges.
